pipe_ctrl: RTL and testbench

Pipeline sequencing controller for the five-stage RV32 core. It drives stall and flush enables for the program counter, IF/ID, ID/EX, EX/MEM and MEM/WB stage registers, and resolves three event sources in a fixed priority: data-memory wait, control-flow redirect from EX, and load-use hazards. It also covers the one-cycle latency of the synchronous instruction ROM by squashing stale fetches after a redirect, and it traps data-memory transactions that never complete.

---
 rtl/pipe_ctrl_if.sv | 58 +++++
 rtl/pipe_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_pipe_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// Pipeline-control bundle between the RV32 datapath and pipe_ctrl.
// Latency: none, plain wires.
// Backpressure: none; stalls/flushes are the pipeline's only flow control.
//
// Ports:
//   ID/EX/MEM status from the datapath: id_rs*_addr_i, id_rs*_re_i, ex_rd_addr_i,
//   ex_is_load_i, ex_redirect_i, ex_target_i, mem_req_i, mem_ack_i.
//   Outputs to the datapath: per-stage stall/flush enables, pc_redirect_o,
//   pc_target_o and mem_err_o.
// The master modport is the datapath side and the slave modport is the controller side.
`ifndef XLEN
`define XLEN 32
`endif

interface pipe_ctrl_if #(
    parameter int XLEN = `XLEN
);
    logic [4:0]      id_rs1_addr_i;
    logic [4:0]      id_rs2_addr_i;
    logic            id_rs1_re_i;
    logic            id_rs2_re_i;
    logic [4:0]      ex_rd_addr_i;
    logic            ex_is_load_i;
    logic            ex_redirect_i;
    logic [XLEN-1:0] ex_target_i;
    logic            mem_req_i;
    logic            mem_ack_i;

    logic            pc_stall_o;
    logic            ifid_stall_o;
    logic            idex_stall_o;
    logic            exmem_stall_o;
    logic            ifid_flush_o;
    logic            idex_flush_o;
    logic            exmem_flush_o;
    logic            memwb_flush_o;
    logic            pc_redirect_o;
    logic [XLEN-1:0] pc_target_o;
    logic            mem_err_o;

    modport master (
        output id_rs1_addr_i, id_rs2_addr_i, id_rs1_re_i, id_rs2_re_i,
               ex_rd_addr_i, ex_is_load_i, ex_redirect_i, ex_target_i,
               mem_req_i, mem_ack_i,
        input  pc_stall_o, ifid_stall_o, idex_stall_o, exmem_stall_o,
               ifid_flush_o, idex_flush_o, exmem_flush_o, memwb_flush_o,
               pc_redirect_o, pc_target_o, mem_err_o
    );

    modport slave (
        input  id_rs1_addr_i, id_rs2_addr_i, id_rs1_re_i, id_rs2_re_i,
               ex_rd_addr_i, ex_is_load_i, ex_redirect_i, ex_target_i,
               mem_req_i, mem_ack_i,
        output pc_stall_o, ifid_stall_o, idex_stall_o, exmem_stall_o,
               ifid_flush_o, idex_flush_o, exmem_flush_o, memwb_flush_o,
               pc_redirect_o, pc_target_o, mem_err_o
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Five-stage RV32 sequencing controller: stall/flush enables, EX redirect, load-use, memory-wait with timeout trap.
// Latency: all responses are combinational in the same cycle as the triggering input.
// Backpressure: a pending data access (mem_req_i && !mem_ack_i) freezes PC..EX/MEM and bubbles MEM/WB until ack or timeout.
//
// Ports: clk_i (rising edge), rst_i (async active-low), bus (pipe_ctrl_if.slave).
// Optional macro PIPE_CTRL_PERF_EN adds stall_cnt_o / flush_cnt_o performance counters.
`ifndef XLEN
`define XLEN 32
`endif

module pipe_ctrl #(
    parameter int              XLEN          = `XLEN,
    parameter int              REFILL_CYCLES = 1,
    parameter int              MEM_TIMEOUT   = 255,
    parameter logic [XLEN-1:0] TRAP_VEC      = XLEN'(32'h0000_0100)
) (
    input  logic        clk_i,
    input  logic        rst_i,
    pipe_ctrl_if.slave  bus
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] flush_cnt_o
`endif
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_REFILL   = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

    localparam logic [2:0] REFILL_CNT = 3'(REFILL_CYCLES);
    localparam logic [9:0] TO_LIMIT   = 10'(MEM_TIMEOUT);

    state_t     state_q, state_d;
    logic [2:0] refill_cnt_q, refill_cnt_d;
    logic [9:0] to_cnt_q, to_cnt_d;
    logic       resume_q, resume_d;

    // Raw controls before the reset override and the flush-beats-stall rule.
    logic            pc_stall, ifid_stall, idex_stall, exmem_stall;
    logic            ifid_flush, idex_flush, exmem_flush, memwb_flush;
    logic            pc_redirect, mem_err;
    logic [XLEN-1:0] pc_target;

    logic mem_wait;
    logic load_use;

    assign mem_wait = bus.mem_req_i && !bus.mem_ack_i;

    // x0 is never a real producer, so a load into x0 cannot create a hazard.
    assign load_use = bus.ex_is_load_i && (bus.ex_rd_addr_i != 5'd0) &&
                      ((bus.id_rs1_re_i && (bus.id_rs1_addr_i == bus.ex_rd_addr_i)) ||
                       (bus.id_rs2_re_i && (bus.id_rs2_addr_i == bus.ex_rd_addr_i)));

    always_comb begin
        state_d      = state_q;
        refill_cnt_d = refill_cnt_q;
        to_cnt_d     = to_cnt_q;
        resume_d     = resume_q;
        pc_stall     = 1'b0;
        ifid_stall   = 1'b0;
        idex_stall   = 1'b0;
        exmem_stall  = 1'b0;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        exmem_flush  = 1'b0;
        memwb_flush  = 1'b0;
        pc_redirect  = 1'b0;
        pc_target    = '0;
        mem_err      = 1'b0;

        case (state_q)
            ST_RUN, ST_REFILL: begin
                if (mem_wait) begin
                    // EX is frozen, so any redirect/hazard seen now is re-presented after the wait.
                    // refill_cnt is kept so an interrupted refill can finish afterwards.
                    pc_stall    = 1'b1;
                    ifid_stall  = 1'b1;
                    idex_stall  = 1'b1;
                    exmem_stall = 1'b1;
                    memwb_flush = 1'b1;
                    resume_d    = (state_q == ST_REFILL);
                    to_cnt_d    = 10'd1;
                    state_d     = ST_MEM_WAIT;
                end else if (bus.ex_redirect_i) begin
                    pc_redirect = 1'b1;
                    pc_target   = bus.ex_target_i;
                    ifid_flush  = 1'b1;
                    idex_flush  = 1'b1;
                    if (REFILL_CYCLES > 0) begin
                        state_d      = ST_REFILL;
                        refill_cnt_d = REFILL_CNT;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else if (state_q == ST_RUN) begin
                    if (load_use) begin
                        pc_stall   = 1'b1;
                        ifid_stall = 1'b1;
                        idex_flush = 1'b1;
                    end
                end else begin
                    // Squash the fetch the ROM returns one cycle late; ID holds a
                    // bubble so the load-use check is skipped here.
                    ifid_flush = 1'b1;
                    if (refill_cnt_q <= 3'd1) begin
                        refill_cnt_d = 3'd0;
                        state_d      = ST_RUN;
                    end else begin
                        refill_cnt_d = refill_cnt_q - 3'd1;
                    end
                end
            end

            ST_MEM_WAIT: begin
                if (bus.mem_ack_i) begin
                    // Ack wins over a same-cycle timeout; everything is released.
                    to_cnt_d = 10'd0;
                    resume_d = 1'b0;
                    if (resume_q && (refill_cnt_q != 3'd0)) begin
                        state_d = ST_REFILL;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else if (to_cnt_q == TO_LIMIT) begin
                    mem_err      = 1'b1;
                    pc_redirect  = 1'b1;
                    pc_target    = TRAP_VEC;
                    ifid_flush   = 1'b1;
                    idex_flush   = 1'b1;
                    exmem_flush  = 1'b1;
                    memwb_flush  = 1'b1;
                    to_cnt_d     = 10'd0;
                    resume_d     = 1'b0;
                    refill_cnt_d = REFILL_CNT;
                    state_d      = (REFILL_CYCLES > 0) ? ST_REFILL : ST_RUN;
                end else begin
                    pc_stall    = 1'b1;
                    ifid_stall  = 1'b1;
                    idex_stall  = 1'b1;
                    exmem_stall = 1'b1;
                    memwb_flush = 1'b1;
                    to_cnt_d    = to_cnt_q + 10'd1;
                end
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= ST_RUN;
            refill_cnt_q <= 3'd0;
            to_cnt_q     <= 10'd0;
            resume_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            refill_cnt_q <= refill_cnt_d;
            to_cnt_q     <= to_cnt_d;
            resume_q     <= resume_d;
        end
    end

    // Reset bubbles every stage register straight away, without waiting for a clock.
    always_comb begin
        if (!rst_i) begin
            bus.pc_stall_o    = 1'b0;
            bus.ifid_stall_o  = 1'b0;
            bus.idex_stall_o  = 1'b0;
            bus.exmem_stall_o = 1'b0;
            bus.ifid_flush_o  = 1'b1;
            bus.idex_flush_o  = 1'b1;
            bus.exmem_flush_o = 1'b1;
            bus.memwb_flush_o = 1'b1;
            bus.pc_redirect_o = 1'b0;
            bus.pc_target_o   = '0;
            bus.mem_err_o     = 1'b0;
        end else begin
            bus.pc_stall_o    = pc_stall;
            bus.ifid_stall_o  = ifid_stall  && !ifid_flush;
            bus.idex_stall_o  = idex_stall  && !idex_flush;
            bus.exmem_stall_o = exmem_stall && !exmem_flush;
            bus.ifid_flush_o  = ifid_flush;
            bus.idex_flush_o  = idex_flush;
            bus.exmem_flush_o = exmem_flush;
            bus.memwb_flush_o = memwb_flush;
            bus.pc_redirect_o = pc_redirect;
            bus.pc_target_o   = pc_target;
            bus.mem_err_o     = mem_err;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q + {31'd0, bus.pc_stall_o};
        flush_cnt_d = flush_cnt_q + {31'd0, bus.idex_flush_o};
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`endif

    // The priority chain never asks for a hold and a bubble on the same register.
    a_ifid_clash: assert property (@(posedge clk_i) disable iff (!rst_i) !(ifid_stall && ifid_flush));
    a_idex_clash: assert property (@(posedge clk_i) disable iff (!rst_i) !(idex_stall && idex_flush));
    a_exmem_clash: assert property (@(posedge clk_i) disable iff (!rst_i) !(exmem_stall && exmem_flush));
    a_err_pulse: assert property (@(posedge clk_i) disable iff (!rst_i) mem_err |=> !mem_err);

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: each driven cycle pushes its expected controls,
// a negedge monitor pops and compares. REFILL_CYCLES=1, MEM_TIMEOUT=8, TRAP_VEC=0x100.
// Control vector order: pc_stall ifid_stall idex_stall exmem_stall ifid_flush idex_flush exmem_flush memwb_flush pc_redirect mem_err.
module tb_pipe_ctrl;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;

    always #5 clk_i = ~clk_i;

    pipe_ctrl_if #(.XLEN(32)) bus ();

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt_o;
    logic [31:0] flush_cnt_o;
`endif

    pipe_ctrl #(
        .XLEN(32),
        .REFILL_CYCLES(1),
        .MEM_TIMEOUT(8),
        .TRAP_VEC(32'h0000_0100)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .bus(bus)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .stall_cnt_o(stall_cnt_o),
        .flush_cnt_o(flush_cnt_o)
`endif
    );

    localparam logic [9:0] C_IDLE = 10'b0000_0000_00;
    localparam logic [9:0] C_RST  = 10'b0000_1111_00;
    localparam logic [9:0] C_LU   = 10'b1100_0100_00;
    localparam logic [9:0] C_RDR  = 10'b0000_1100_10;
    localparam logic [9:0] C_RFL  = 10'b0000_1000_00;
    localparam logic [9:0] C_MW   = 10'b1111_0001_00;
    localparam logic [9:0] C_TO   = 10'b0000_1111_11;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        re1;
        logic        re2;
        logic [4:0]  rd;
        logic        ld;
        logic        rdr;
        logic [31:0] tgt;
        logic        req;
        logic        ack;
    } in_t;

    typedef struct {
        logic [9:0]  ctl;
        logic [31:0] tgt;
        string       nm;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic in_t mk_in(input logic ld, input logic [4:0] rd,
                                  input logic [4:0] rs1, input logic re1,
                                  input logic [4:0] rs2, input logic re2,
                                  input logic rdr, input logic [31:0] tgt,
                                  input logic req, input logic ack);
        in_t v;
        v.ld = ld;   v.rd = rd;
        v.rs1 = rs1; v.re1 = re1;
        v.rs2 = rs2; v.re2 = re2;
        v.rdr = rdr; v.tgt = tgt;
        v.req = req; v.ack = ack;
        return v;
    endfunction

    function automatic in_t idle();
        return mk_in(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    endfunction

    function automatic in_t lu5();
        return mk_in(1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    endfunction

    function automatic in_t redir(input logic [31:0] t);
        return mk_in(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, t, 1'b0, 1'b0);
    endfunction

    function automatic in_t memx(input logic ack, input logic rdr, input logic [31:0] t);
        return mk_in(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, rdr, t, 1'b1, ack);
    endfunction

    // One cycle: drive just after the rising edge, record what the controller must show.
    task automatic step(input logic rst, input in_t i, input logic [9:0] ec,
                        input logic [31:0] et, input string nm);
        @(posedge clk_i);
        #1;
        rst_i             = rst;
        bus.id_rs1_addr_i = i.rs1;
        bus.id_rs2_addr_i = i.rs2;
        bus.id_rs1_re_i   = i.re1;
        bus.id_rs2_re_i   = i.re2;
        bus.ex_rd_addr_i  = i.rd;
        bus.ex_is_load_i  = i.ld;
        bus.ex_redirect_i = i.rdr;
        bus.ex_target_i   = i.tgt;
        bus.mem_req_i     = i.req;
        bus.mem_ack_i     = i.ack;
        exp_q.push_back('{ec, et, nm});
    endtask

    // Monitor: the controller presents a full control word every cycle.
    initial begin
        forever begin
            @(negedge clk_i);
            if (exp_q.size() != 0) begin
                exp_t e;
                logic [9:0] act;
                e   = exp_q.pop_front();
                act = {bus.pc_stall_o, bus.ifid_stall_o, bus.idex_stall_o, bus.exmem_stall_o,
                       bus.ifid_flush_o, bus.idex_flush_o, bus.exmem_flush_o, bus.memwb_flush_o,
                       bus.pc_redirect_o, bus.mem_err_o};
                n_cmp++;
                if (act !== e.ctl || bus.pc_target_o !== e.tgt) begin
                    n_bad++;
                    $display("FAIL %s: got ctl=%b tgt=%h, want ctl=%b tgt=%h",
                             e.nm, act, bus.pc_target_o, e.ctl, e.tgt);
                end
            end
        end
    end

    initial begin
        bus.id_rs1_addr_i = 5'd0;
        bus.id_rs2_addr_i = 5'd0;
        bus.id_rs1_re_i   = 1'b0;
        bus.id_rs2_re_i   = 1'b0;
        bus.ex_rd_addr_i  = 5'd0;
        bus.ex_is_load_i  = 1'b0;
        bus.ex_redirect_i = 1'b0;
        bus.ex_target_i   = 32'h0;
        bus.mem_req_i     = 1'b0;
        bus.mem_ack_i     = 1'b0;

        // Reset state and release.
        step(1'b0, idle(), C_RST, 32'h0, "reset0");
        step(1'b0, lu5(), C_RST, 32'h0, "reset1");
        step(1'b1, idle(), C_IDLE, 32'h0, "idle");

        // Load-use on rs1, rd=x0, rs2 with and without read-enable.
        step(1'b1, lu5(), C_LU, 32'h0, "lu_rs1");
        step(1'b1, idle(), C_IDLE, 32'h0, "lu_bubble");
        step(1'b1, mk_in(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0),
             C_IDLE, 32'h0, "lu_x0");
        step(1'b1, mk_in(1'b1, 5'd7, 5'd3, 1'b1, 5'd7, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0),
             C_LU, 32'h0, "lu_rs2");
        step(1'b1, mk_in(1'b1, 5'd7, 5'd3, 1'b1, 5'd7, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0),
             C_IDLE, 32'h0, "lu_rs2_nore");
        step(1'b1, mk_in(1'b0, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0),
             C_IDLE, 32'h0, "lu_noload");

        // Redirect, one refill cycle, back to RUN.
        step(1'b1, redir(32'h40), C_RDR, 32'h40, "rdr");
        step(1'b1, idle(), C_RFL, 32'h0, "rdr_refill");
        step(1'b1, idle(), C_IDLE, 32'h0, "rdr_run");

        // Load-use ignored during refill, honoured again in RUN.
        step(1'b1, redir(32'h48), C_RDR, 32'h48, "rdr2");
        step(1'b1, lu5(), C_RFL, 32'h0, "refill_lu_ign");
        step(1'b1, lu5(), C_LU, 32'h0, "run_lu");

        // Redirect during refill restarts the refill.
        step(1'b1, redir(32'h50), C_RDR, 32'h50, "rdr3");
        step(1'b1, redir(32'h54), C_RDR, 32'h54, "rdr_in_refill");
        step(1'b1, idle(), C_RFL, 32'h0, "rdr_restart_refill");
        step(1'b1, idle(), C_IDLE, 32'h0, "rdr_restart_run");

        // Memory wait with a redirect held off until after the ack.
        for (int k = 0; k < 4; k++) step(1'b1, memx(1'b0, 1'b1, 32'h80), C_MW, 32'h0, "memwait");
        step(1'b1, memx(1'b1, 1'b1, 32'h80), C_IDLE, 32'h0, "mem_ack");
        step(1'b1, redir(32'h80), C_RDR, 32'h80, "mem_rdr_after");
        step(1'b1, idle(), C_RFL, 32'h0, "mem_rdr_refill");
        step(1'b1, idle(), C_IDLE, 32'h0, "mem_rdr_run");

        // Timeout: 8th MEM_WAIT-state cycle traps.
        for (int k = 0; k < 8; k++) step(1'b1, memx(1'b0, 1'b0, 32'h0), C_MW, 32'h0, "to_wait");
        step(1'b1, memx(1'b0, 1'b0, 32'h0), C_TO, 32'h100, "timeout");
        step(1'b1, idle(), C_RFL, 32'h0, "to_refill");
        step(1'b1, idle(), C_IDLE, 32'h0, "to_run");

        // Ack on the timeout cycle wins.
        for (int k = 0; k < 8; k++) step(1'b1, memx(1'b0, 1'b0, 32'h0), C_MW, 32'h0, "ack8_wait");
        step(1'b1, memx(1'b1, 1'b0, 32'h0), C_IDLE, 32'h0, "ack8_noerr");
        step(1'b1, idle(), C_IDLE, 32'h0, "ack8_run");

        // Wait entered from REFILL resumes the refill after the ack.
        step(1'b1, redir(32'h60), C_RDR, 32'h60, "rdr_pre_wait");
        step(1'b1, memx(1'b0, 1'b0, 32'h0), C_MW, 32'h0, "refill_wait");
        step(1'b1, memx(1'b1, 1'b0, 32'h0), C_IDLE, 32'h0, "refill_wait_ack");
        step(1'b1, idle(), C_RFL, 32'h0, "refill_resumed");
        step(1'b1, idle(), C_IDLE, 32'h0, "refill_resume_run");

        // Reset asserted mid-refill, then RUN after release.
        step(1'b1, redir(32'h70), C_RDR, 32'h70, "rdr_pre_rst");
        step(1'b0, idle(), C_RST, 32'h0, "rst_mid_refill");
        step(1'b0, lu5(), C_RST, 32'h0, "rst_held");
        step(1'b1, lu5(), C_LU, 32'h0, "rst_release_run");
        step(1'b1, idle(), C_IDLE, 32'h0, "rst_release_idle");

`ifdef PIPE_CTRL_PERF_EN
        step(1'b0, idle(), C_RST, 32'h0, "perf_rst");
        for (int k = 0; k < 3; k++) step(1'b1, lu5(), C_LU, 32'h0, "perf_lu");
        step(1'b1, redir(32'h90), C_RDR, 32'h90, "perf_rdr");
        step(1'b1, idle(), C_RFL, 32'h0, "perf_refill");
        step(1'b1, idle(), C_IDLE, 32'h0, "perf_idle");
`endif

        // Drain the scoreboard within a bounded number of cycles.
        for (int k = 0; k < 5 && exp_q.size() != 0; k++) @(negedge clk_i);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, want 0", exp_q.size());
        end

`ifdef PIPE_CTRL_PERF_EN
        n_cmp++;
        if (stall_cnt_o !== 32'd3) begin
            n_bad++;
            $display("FAIL stall_cnt: got %0d, want 3", stall_cnt_o);
        end
        n_cmp++;
        if (flush_cnt_o !== 32'd4) begin
            n_bad++;
            $display("FAIL flush_cnt: got %0d, want 4", flush_cnt_o);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
